cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 110 +++++++++++
 tb/tb_cdb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one ready reservation station per cycle, lowest index first.
// A station that has waited STARVE_LIMIT cycles is escalated through a rotating starvation scan.
module cdb_arbiter #(
    parameter int NUM_RS       = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RS-1:0]            unit_done,
    input  logic [NUM_RS*DATA_WIDTH-1:0] unit_result,
    input  logic [NUM_RS-1:0]            op_has_rd,
    input  logic [NUM_RS-1:0]            cancel,
    input  logic                         cdb_hold,
    output logic [NUM_RS-1:0]            do_retire,
    output logic                         cdb_valid,
    output logic [DATA_WIDTH-1:0]        cdb_result,
    output logic [2:0]                   cdb_rs_id,
    output logic                         starved_any,
    output logic [31:0]                  retire_count
);

    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAST_RS = 3'(NUM_RS - 1);

    logic [3:0]        wait_cnt [NUM_RS];
    logic [2:0]        rr_ptr;
    logic [NUM_RS-1:0] elig;
    logic [NUM_RS-1:0] starved;
    logic              any_at_limit;
    logic              grant;
    logic              from_starve;
    logic [2:0]        gnt_idx;
    int unsigned       scan_idx;

    always_comb begin
        elig         = unit_done & ~cancel & {NUM_RS{~cdb_hold & ~rst}};
        starved      = '0;
        any_at_limit = 1'b0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            starved[i]   = (wait_cnt[i] >= LIMIT) & elig[i];
            any_at_limit = any_at_limit | (wait_cnt[i] >= LIMIT);
        end

        grant       = 1'b0;
        from_starve = 1'b0;
        gnt_idx     = '0;
        scan_idx    = 0;
        if (|starved) begin
            // Rotating scan starting at rr_ptr, wrapping modulo NUM_RS
            for (int unsigned k = 0; k < NUM_RS; k++) begin
                scan_idx = (int'(rr_ptr) + k) % NUM_RS;
                if (!grant && starved[scan_idx]) begin
                    grant       = 1'b1;
                    from_starve = 1'b1;
                    gnt_idx     = 3'(scan_idx);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_RS; i++) begin
                if (!grant && elig[i]) begin
                    grant   = 1'b1;
                    gnt_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin
        do_retire  = '0;
        cdb_valid  = 1'b0;
        cdb_result = '0;
        cdb_rs_id  = '0;
        if (grant) begin
            cdb_rs_id = gnt_idx;
            for (int unsigned i = 0; i < NUM_RS; i++) begin
                if (gnt_idx == 3'(i)) begin
                    do_retire[i] = 1'b1;
                    cdb_valid    = op_has_rd[i];
                    cdb_result   = unit_result[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_RS; i++) wait_cnt[i] <= '0;
            rr_ptr       <= '0;
            retire_count <= '0;
            starved_any  <= 1'b0;
        end else begin
            // Waiting continues to accumulate under cdb_hold; only grant or drop clears it
            for (int unsigned i = 0; i < NUM_RS; i++) begin
                if (do_retire[i])
                    wait_cnt[i] <= '0;
                else if (unit_done[i] & ~cancel[i])
                    wait_cnt[i] <= (wait_cnt[i] == 4'hf) ? wait_cnt[i] : wait_cnt[i] + 4'd1;
                else
                    wait_cnt[i] <= '0;
            end
            if (grant && from_starve)
                rr_ptr <= (gnt_idx == LAST_RS) ? 3'd0 : gnt_idx + 3'd1;
            if (grant)
                retire_count <= retire_count + 32'd1;
            starved_any <= any_at_limit;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int SL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      unit_done, op_has_rd, cancel;
    logic [N*DW-1:0]   unit_result;
    logic              cdb_hold;
    logic [N-1:0]      do_retire;
    logic              cdb_valid;
    logic [DW-1:0]     cdb_result;
    logic [2:0]        cdb_rs_id;
    logic              starved_any;
    logic [31:0]       retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_wait [N];
    int          m_rr;
    logic [31:0] m_cnt;
    logic        m_starved_any;
    int          m_g;
    logic        m_from_starve;

    cdb_arbiter #(.NUM_RS(N), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .unit_done(unit_done), .unit_result(unit_result),
        .op_has_rd(op_has_rd), .cancel(cancel), .cdb_hold(cdb_hold),
        .do_retire(do_retire), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
        .cdb_rs_id(cdb_rs_id), .starved_any(starved_any), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Starved candidate nearest to m_rr in rotation order wins; else lowest ready index
    function automatic void model_pick();
        int best_d = N;
        m_g = -1;
        m_from_starve = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (unit_done[i] && !cancel[i] && !cdb_hold && !rst && m_wait[i] >= SL) begin
                int d = (i - m_rr + N) % N;
                if (d < best_d) begin
                    best_d = d;
                    m_g = i;
                end
            end
        end
        if (m_g >= 0) begin
            m_from_starve = 1'b1;
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (unit_done[i] && !cancel[i] && !cdb_hold && !rst) m_g = i;
        end
    endfunction

    task automatic settle_check();
        logic [N-1:0] e_ret;
        #3;
        model_pick();
        e_ret = '0;
        if (m_g >= 0) e_ret[m_g] = 1'b1;
        check("do_retire", 32'(do_retire), 32'(e_ret));
        check("cdb_valid", 32'(cdb_valid), (m_g >= 0) ? 32'(op_has_rd[m_g]) : 32'd0);
        check("cdb_result", cdb_result, (m_g >= 0) ? unit_result[m_g*DW +: DW] : 32'd0);
        check("cdb_rs_id", 32'(cdb_rs_id), (m_g >= 0) ? 32'(m_g) : 32'd0);
        check("starved_any", 32'(starved_any), 32'(m_starved_any));
        check("retire_count", retire_count, m_cnt);
    endtask

    task automatic advance();
        logic any_lim;
        model_pick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            m_rr = 0; m_cnt = '0; m_starved_any = 1'b0;
        end else begin
            any_lim = 1'b0;
            for (int i = 0; i < N; i++) if (m_wait[i] >= SL) any_lim = 1'b1;
            m_starved_any = any_lim;
            for (int i = 0; i < N; i++) begin
                if (i == m_g) m_wait[i] = 0;
                else if (unit_done[i] && !cancel[i]) m_wait[i] = (m_wait[i] + 1 > 15) ? 15 : m_wait[i] + 1;
                else m_wait[i] = 0;
            end
            if (m_from_starve) m_rr = (m_g + 1) % N;
            if (m_g >= 0) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        unit_done = '0; op_has_rd = '0; cancel = '0; cdb_hold = 1'b0; unit_result = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        settle_check();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        m_rr = 0; m_cnt = '0; m_starved_any = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        settle_check();
        advance();

        // Single RS3 retire with result
        unit_done = 8'h08; op_has_rd = 8'h08; unit_result[3*DW +: DW] = 32'hDEADBEEF;
        settle_check();
        check("s1_retire", 32'(do_retire), 32'h08);
        check("s1_valid", 32'(cdb_valid), 32'd1);
        check("s1_id", 32'(cdb_rs_id), 32'd3);
        check("s1_result", cdb_result, 32'hDEADBEEF);
        advance();
        idle_inputs();
        settle_check();
        check("s1_count", retire_count, 32'd1);
        advance();

        // RS0 and RS5 contend; RS5 escalates after STARVE_LIMIT waits
        do_reset();
        unit_done = 8'h21; op_has_rd = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            settle_check();
            check("s2_grant", 32'(do_retire), (c < 4) ? 32'h01 : 32'h20);
            if (c == 4) check("s2_starved_pre", 32'(starved_any), 32'd0);
            advance();
        end
        settle_check();
        check("s2_starved_post", 32'(starved_any), 32'd1);
        check("s2_rr_ptr", 32'(dut.rr_ptr), 32'd6);

        // Reset while RS0 ready
        rst = 1'b1; unit_done = 8'h01;
        settle_check();
        check("s3_rst_retire", 32'(do_retire), 32'd0);
        check("s3_rst_valid", 32'(cdb_valid), 32'd0);
        advance();
        rst = 1'b0; idle_inputs();
        settle_check();
        check("s3_count", retire_count, 32'd0);
        for (int i = 0; i < N; i++) check("s3_wait", 32'(dut.wait_cnt[i]), 32'd0);
        advance();

        // Result-less retire
        unit_done = 8'h04; op_has_rd = 8'h00;
        settle_check();
        check("s4_retire", 32'(do_retire), 32'h04);
        check("s4_valid", 32'(cdb_valid), 32'd0);
        check("s4_id", 32'(cdb_rs_id), 32'd2);
        advance();

        // Cancel on RS1 with RS4 ready
        unit_done = 8'h12; cancel = 8'h02; op_has_rd = 8'hFF;
        settle_check();
        check("s5_retire", 32'(do_retire), 32'h10);
        advance();
        check("s5_wait1", 32'(dut.wait_cnt[1]), 32'd0);
        cancel = '0;

        // Hold for 6 cycles, then starved stations drain in rotation order
        do_reset();
        unit_done = 8'h42; op_has_rd = 8'hFF; cdb_hold = 1'b1;
        for (int c = 0; c < 6; c++) begin
            settle_check();
            check("s6_hold", 32'(do_retire), 32'd0);
            advance();
        end
        check("s6_wait1", 32'(dut.wait_cnt[1]), 32'd6);
        check("s6_wait6", 32'(dut.wait_cnt[6]), 32'd6);
        cdb_hold = 1'b0;
        settle_check();
        check("s6_rel1", 32'(do_retire), 32'h02);
        advance();
        settle_check();
        check("s6_rel2", 32'(do_retire), 32'h40);
        advance();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            unit_done = 8'($urandom);
            op_has_rd = 8'($urandom);
            cancel    = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cdb_hold  = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) unit_result[i*DW +: DW] = $urandom;
            settle_check();
            advance();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
